// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array result drain: default sizes,
// width derivations, drain FSM states and saturation limits.
package systolic_pkg;

    localparam int DEF_ARRAY_SIZE = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int SHIFT_W        = 6;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FLUSH,
        DONE
    } drain_state_t;

    // Accumulator lane width carried by the array for a given element width.
    function automatic int acc_width(input int dw);
        return 2 * dw + 5;
    endfunction

    // matrix_index width: one extra bit above the diagonal count.
    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Per-bank write address width.
    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

    // Largest signed value of a dw-bit result, zero-extended to 128 bits.
    function automatic logic [127:0] sat_hi(input int dw);
        return (128'(1) << (dw - 1)) - 128'(1);
    endfunction

    // Smallest signed value of a dw-bit result, two's complement in 128 bits.
    function automatic logic [127:0] sat_lo(input int dw);
        return ~sat_hi(dw);
    endfunction

endpackage

// File: rtl/systolic_requant.sv
// One requantization lane: round half up, arithmetic right shift, saturate to
// DATA_WIDTH. With SYSTOLIC_DRAIN_RELU_EN defined, negative results become 0
// after saturation (the ReLU clamp itself never raises sat).
module systolic_requant
    import systolic_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int ACC_W      = acc_width(DATA_WIDTH)
) (
    input  logic [ACC_W-1:0]      acc,
    input  logic [SHIFT_W-1:0]    shift_amt,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  sat
);

    localparam logic signed [ACC_W:0] SAT_HI = $signed((ACC_W + 1)'(sat_hi(DATA_WIDTH)));
    localparam logic signed [ACC_W:0] SAT_LO = $signed((ACC_W + 1)'(sat_lo(DATA_WIDTH)));

    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    // Round, shift and clip one accumulator; one guard bit keeps the rounding add exact.
    always_comb begin
        acc_ext = $signed({acc[ACC_W-1], acc});
        rnd     = '0;
        if (shift_amt != '0) begin
            rnd = (ACC_W + 1)'(1) << (shift_amt - SHIFT_W'(1));
        end
        sum     = acc_ext + rnd;
        shifted = sum >>> shift_amt;
        sat     = 1'b0;
        result  = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_HI) begin
            result = SAT_HI[DATA_WIDTH-1:0];
            sat    = 1'b1;
        end else if (shifted < SAT_LO) begin
            result = SAT_LO[DATA_WIDTH-1:0];
            sat    = 1'b1;
        end
`ifdef SYSTOLIC_DRAIN_RELU_EN
        if (result[DATA_WIDTH-1]) begin
            result = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/systolic_drain.sv
// Result-side drain for the systolic array. Sweeps matrix_index over all wrapped
// anti-diagonals, requantizes each lane and writes it to one output bank per row.
// Two register stages (capture, requant) sit between the array and the banks;
// stall freezes the index counter and both stages. Optional ReLU on the written
// results is selected with the SYSTOLIC_DRAIN_RELU_EN macro (see systolic_requant).
module systolic_drain
    import systolic_pkg::*;
#(
    parameter  int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int ACC_W      = acc_width(DATA_WIDTH),
    localparam int IDX_W      = idx_width(ARRAY_SIZE),
    localparam int AW         = addr_width(ARRAY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [SHIFT_W-1:0]               shift_amt,
    input  logic                             stall,
    output logic [IDX_W-1:0]                 matrix_index,
    input  logic [ARRAY_SIZE*ACC_W-1:0]      mul_outcome,
    output logic [ARRAY_SIZE-1:0]            wr_en,
    output logic [ARRAY_SIZE*AW-1:0]         wr_addr,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data,
    output logic                             busy,
    output logic                             done,
    output logic                             sat_flag
);

    drain_state_t state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [SHIFT_W-1:0]               shift_q, shift_d;
    logic                             s1_valid_q, s1_valid_d;
    logic [ARRAY_SIZE*ACC_W-1:0]      s1_lanes_q, s1_lanes_d;
    logic [AW-1:0]                    s1_idx_q, s1_idx_d;
    logic                             s2_valid_q, s2_valid_d;
    logic [ARRAY_SIZE*AW-1:0]         s2_addr_q, s2_addr_d;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                             sat_q, sat_d;

    logic [ARRAY_SIZE*DATA_WIDTH-1:0] lane_data;
    logic [ARRAY_SIZE*AW-1:0]         lane_addr;
    logic [ARRAY_SIZE-1:0]            lane_sat;

    // Per lane: requantize the captured accumulator; bank address is the wrapped column.
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
        systolic_requant #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_requant (
            .acc      (s1_lanes_q[gi*ACC_W +: ACC_W]),
            .shift_amt(shift_q),
            .result   (lane_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .sat      (lane_sat[gi])
        );
        assign lane_addr[gi*AW +: AW] = s1_idx_q - AW'(gi);
    end

    // Next state and diagonal counter; the counter only advances on non-stalled sweep cycles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    shift_d = shift_amt;
                end
            end
            SWEEP: begin
                if (!stall) begin
                    if (idx_q == IDX_W'(ARRAY_SIZE - 1)) begin
                        state_d = FLUSH;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            // Leave once S1 is empty and the S2 write (if any) goes out this cycle.
            FLUSH: begin
                if (!stall && !s1_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pipeline advance: S1 captures the array lanes, S2 captures requantized results.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lanes_d = s1_lanes_q;
        s1_idx_d   = s1_idx_q;
        s2_valid_d = s2_valid_q;
        s2_addr_d  = s2_addr_q;
        s2_data_d  = s2_data_q;
        sat_d      = sat_q;
        if (state_q == IDLE && start) begin
            sat_d = 1'b0;
        end
        if (!stall) begin
            s1_valid_d = (state_q == SWEEP);
            if (state_q == SWEEP) begin
                s1_lanes_d = mul_outcome;
                s1_idx_d   = idx_q[AW-1:0];
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_addr_d = lane_addr;
                s2_data_d = lane_data;
                if (|lane_sat) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    // State and pipeline registers; async reset abandons any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_lanes_q <= '0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            s1_valid_q <= s1_valid_d;
            s1_lanes_q <= s1_lanes_d;
            s1_idx_q   <= s1_idx_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
            sat_q      <= sat_d;
        end
    end

    // A held S2 write is withheld while stalled and issued when stall drops.
    assign wr_en        = {ARRAY_SIZE{s2_valid_q & ~stall}};
    assign wr_addr      = s2_addr_q;
    assign wr_data      = s2_data_q;
    assign matrix_index = idx_q;
    assign busy         = (state_q == SWEEP) || (state_q == FLUSH);
    assign done         = (state_q == DONE);
    assign sat_flag     = sat_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: a small array model drives mul_outcome
// from a matrix; each sweep pushes its expected bank writes, a monitor thread
// pops and compares on every write cycle.
module tb_systolic_drain;

    localparam int N     = 32;
    localparam int DW    = 32;
    localparam int ACC_W = 2 * DW + 5;
    localparam int AW    = 5;
    localparam int IDX_W = 6;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [5:0]          shift_amt;
    logic                stall;
    logic [IDX_W-1:0]    matrix_index;
    logic [N*ACC_W-1:0]  mul_outcome;
    logic [N-1:0]        wr_en;
    logic [N*AW-1:0]     wr_addr;
    logic [N*DW-1:0]     wr_data;
    logic                busy;
    logic                done;
    logic                sat_flag;

    logic [ACC_W-1:0] mat     [N][N];
    logic [DW-1:0]    exp_tab [N][N];

    logic [N*AW-1:0] exp_a_q [$];
    logic [N*DW-1:0] exp_d_q [$];

    int n_checks;
    int n_fail;

    systolic_drain #(
        .ARRAY_SIZE(N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .shift_amt   (shift_amt),
        .stall       (stall),
        .matrix_index(matrix_index),
        .mul_outcome (mul_outcome),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: lane i presents element [i][(idx - i) mod N].
    always_comb begin
        mul_outcome = '0;
        for (int i = 0; i < N; i++) begin
            mul_outcome[i*ACC_W +: ACC_W] = mat[i][(int'(matrix_index) - i) & (N - 1)];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Background matrix: pattern i*100+j (passes unchanged at shift 0) or all zero.
    task automatic fill_bg(input bit pattern);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mat[i][j]     = pattern ? ACC_W'(i * 100 + j) : '0;
                exp_tab[i][j] = pattern ? DW'(i * 100 + j) : '0;
            end
        end
    endtask

    task automatic expect_sweep();
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        int col;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                col = (k - i) & (N - 1);
                a[i*AW +: AW] = AW'(col);
                d[i*DW +: DW] = exp_tab[i][col];
            end
            exp_a_q.push_back(a);
            exp_d_q.push_back(d);
        end
    endtask

    task automatic monitor_loop();
        logic [N*AW-1:0] ea;
        logic [N*DW-1:0] ed;
        int bad;
        forever begin
            @(negedge clk);
            #2;
            if (wr_en != '0) begin
                n_checks++;
                if (exp_a_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got wr_en %0h with no write expected", wr_en);
                end else begin
                    ea  = exp_a_q.pop_front();
                    ed  = exp_d_q.pop_front();
                    bad = -1;
                    for (int l = N - 1; l >= 0; l--) begin
                        if (wr_addr[l*AW +: AW] !== ea[l*AW +: AW] ||
                            wr_data[l*DW +: DW] !== ed[l*DW +: DW] || wr_en[l] !== 1'b1) begin
                            bad = l;
                        end
                    end
                    if (bad >= 0) begin
                        n_fail++;
                        $display("FAIL bank_write lane %0d: got en %0b addr %0d data %0h expected en 1 addr %0d data %0h",
                                 bad, wr_en[bad], wr_addr[bad*AW +: AW], wr_data[bad*DW +: DW],
                                 ea[bad*AW +: AW], ed[bad*DW +: DW]);
                    end
                end
            end
        end
    endtask

    // One sweep; cycle 1 is the cycle after the edge that samples start.
    task automatic run_sweep(input logic [5:0] sh, input int stall_idx, input int rst_idx,
                             input int pulse_cyc, output int done_cyc,
                             output int first_wr, output int last_wr);
        int c;
        int stalls;
        bit fin;
        done_cyc = -1;
        first_wr = -1;
        last_wr  = -1;
        stalls   = 0;
        fin      = 1'b0;
        @(negedge clk);
        shift_amt = sh;
        start     = 1'b1;
        stall     = 1'b0;
        @(negedge clk);
        c = 1;
        while (!fin && c < 200) begin
            start = (c == pulse_cyc);
            stall = 1'b0;
            if (rst_idx >= 0 && matrix_index == IDX_W'(rst_idx)) begin
                chk("sat_before_reset", 64'(sat_flag), 64'd1);
                rst_n = 1'b0;
                #1;
                chk("reset_wr_en", 64'(wr_en), 64'd0);
                chk("reset_busy", 64'(busy), 64'd0);
                chk("reset_idx", 64'(matrix_index), 64'd0);
                chk("reset_sat", 64'(sat_flag), 64'd0);
                fin = 1'b1;
            end else begin
                if (stall_idx >= 0 && matrix_index == IDX_W'(stall_idx) && stalls < 3) begin
                    stall = 1'b1;
                    stalls++;
                end
                #1;
                if (c == 1) begin
                    chk("busy_cycle1", 64'(busy), 64'd1);
                    chk("idx_cycle1", 64'(matrix_index), 64'd0);
                    chk("sat_cleared_on_start", 64'(sat_flag), 64'd0);
                end
                if (stall) begin
                    chk("stall_idx_hold", 64'(matrix_index), 64'(stall_idx));
                    chk("stall_wr_en", 64'(wr_en), 64'd0);
                end
                if (wr_en != '0) begin
                    if (first_wr < 0) first_wr = c;
                    last_wr = c;
                end
                if (done) begin
                    done_cyc = c;
                    chk("busy_at_done", 64'(busy), 64'd0);
                    fin = 1'b1;
                end
            end
            if (!fin) begin
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got no done after %0d cycles, required done", c);
        end
    endtask

    int dc, fw, lw;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        start     = 1'b0;
        stall     = 1'b0;
        shift_amt = '0;
        rst_n     = 1'b0;
        fill_bg(1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_idx", 64'(matrix_index), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr_zero", 64'(wr_addr == '0), 64'd1);
        chk("rst_wr_data_zero", 64'(wr_data == '0), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fork
            monitor_loop();
        join_none

        // T1: plain sweep, shift 0
        fill_bg(1'b1);
        expect_sweep();
        run_sweep(6'd0, -1, -1, -1, dc, fw, lw);
        chk("t1_done_cycle", 64'(dc), 64'd35);
        chk("t1_first_write", 64'(fw), 64'd3);
        chk("t1_last_write", 64'(lw), 64'd34);
        chk("t1_sat", 64'(sat_flag), 64'd0);
        chk("t1_all_written", 64'(exp_a_q.size()), 64'd0);
        @(negedge clk);
        #1;
        chk("t1_done_one_cycle", 64'(done), 64'd0);

        // T2: saturation both ways, sticky flag
        fill_bg(1'b1);
        mat[3][5]     = ACC_W'(longint'(1) << 40);
        exp_tab[3][5] = 32'h7FFF_FFFF;
        mat[7][9]     = ACC_W'(-(longint'(1) << 40));
`ifdef SYSTOLIC_DRAIN_RELU_EN
        exp_tab[7][9] = 32'h0000_0000;
`else
        exp_tab[7][9] = 32'h8000_0000;
`endif
        expect_sweep();
        run_sweep(6'd0, -1, -1, -1, dc, fw, lw);
        chk("t2_done_cycle", 64'(dc), 64'd35);
        chk("t2_sat_set", 64'(sat_flag), 64'd1);
        chk("t2_all_written", 64'(exp_a_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("t2_sat_sticky", 64'(sat_flag), 64'd1);

        // T3: rounding, shift 1
        fill_bg(1'b0);
        mat[0][0] = ACC_W'(5);  exp_tab[0][0] = 32'd3;
        mat[1][1] = ACC_W'(-5);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        exp_tab[1][1] = 32'd0;
`else
        exp_tab[1][1] = 32'hFFFF_FFFE;
`endif
        expect_sweep();
        run_sweep(6'd1, -1, -1, -1, dc, fw, lw);
        chk("t3a_done_cycle", 64'(dc), 64'd35);
        chk("t3a_sat", 64'(sat_flag), 64'd0);
        chk("t3a_all_written", 64'(exp_a_q.size()), 64'd0);

        // T3: rounding, shift 2
        fill_bg(1'b0);
        mat[4][4] = ACC_W'(4); exp_tab[4][4] = 32'd1;
        mat[5][6] = ACC_W'(6); exp_tab[5][6] = 32'd2;
        expect_sweep();
        run_sweep(6'd2, -1, -1, -1, dc, fw, lw);
        chk("t3b_all_written", 64'(exp_a_q.size()), 64'd0);

        // T3: rounding, shift 63
        fill_bg(1'b0);
        mat[2][3] = ACC_W'(-1);                     exp_tab[2][3] = 32'd0;
        mat[6][7] = ACC_W'(longint'(1) << 40);      exp_tab[6][7] = 32'd0;
        expect_sweep();
        run_sweep(6'd63, -1, -1, -1, dc, fw, lw);
        chk("t3c_sat", 64'(sat_flag), 64'd0);
        chk("t3c_all_written", 64'(exp_a_q.size()), 64'd0);

        // T4: three stall cycles while idx = 10
        fill_bg(1'b1);
        expect_sweep();
        run_sweep(6'd0, 10, -1, -1, dc, fw, lw);
        chk("t4_done_cycle", 64'(dc), 64'd38);
        chk("t4_all_written_once", 64'(exp_a_q.size()), 64'd0);

        // T5: async reset while idx = 17
        fill_bg(1'b1);
        mat[0][0]     = ACC_W'(longint'(1) << 40);
        exp_tab[0][0] = 32'h7FFF_FFFF;
        expect_sweep();
        run_sweep(6'd0, -1, 17, -1, dc, fw, lw);
        @(negedge clk);
        rst_n = 1'b1;
        exp_a_q.delete();
        exp_d_q.delete();

        // T6: restart after reset, ignored mid-sweep start, negative lane
        fill_bg(1'b1);
        mat[2][4] = ACC_W'(-7);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        exp_tab[2][4] = 32'd0;
`else
        exp_tab[2][4] = 32'hFFFF_FFF9;
`endif
        expect_sweep();
        run_sweep(6'd0, -1, -1, 10, dc, fw, lw);
        chk("t6_done_cycle", 64'(dc), 64'd35);
        chk("t6_sat", 64'(sat_flag), 64'd0);
        chk("t6_all_written", 64'(exp_a_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_idle_after", 64'(busy), 64'd0);
        chk("t6_no_extra_writes", 64'(exp_a_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
